// File: rtl/ssp_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory fetch pair, issue-side pop/redirect, and the two oldest queue entries.
// The master modport is the fetch queue; the slave modport is memory plus decode/issue.
interface ssp_fetch_queue_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
);
    logic [PC_W-1:0]          imem_addr0;
    logic [PC_W-1:0]          imem_addr1;
    logic [31:0]              imem_data0;
    logic [31:0]              imem_data1;
    logic [1:0]               pop_cnt;
    logic                     redirect;
    logic [PC_W-1:0]          redirect_pc;
    logic                     out0_valid;
    logic [31:0]              out0_instr;
    logic [PC_W-1:0]          out0_pc;
    logic                     out1_valid;
    logic [31:0]              out1_instr;
    logic [PC_W-1:0]          out1_pc;
    logic [$clog2(DEPTH):0]   fq_count;

    modport master (
        output imem_addr0, imem_addr1,
        input  imem_data0, imem_data1,
        input  pop_cnt, redirect, redirect_pc,
        output out0_valid, out0_instr, out0_pc,
        output out1_valid, out1_instr, out1_pc,
        output fq_count
    );

    modport slave (
        input  imem_addr0, imem_addr1,
        output imem_data0, imem_data1,
        output pop_cnt, redirect, redirect_pc,
        input  out0_valid, out0_instr, out0_pc,
        input  out1_valid, out1_instr, out1_pc,
        input  fq_count
    );
endinterface

// File: rtl/ssp_fetch_queue.sv
// Dual-issue sequential fetch plus in-order fetch queue; redirect flushes and restarts fetch.
// Optional macro FQ_NOP_SQUASH_EN drops NOP words (opcode 6'b111111) at push time.
module ssp_fetch_queue #(
    parameter int PC_W     = 10,
    parameter int DEPTH    = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk1,
    input  logic              reset,
    ssp_fetch_queue_if.master fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    logic [PC_W-1:0]  fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PC_W-1:0]  slot_pc    [2];
    logic [31:0]      slot_instr [2];
    logic [1:0]       slot_keep;

    logic [1:0]       pop_clip;
    logic [CNT_W-1:0] eff_pop;
    logic [CNT_W-1:0] free_slots;
    logic             push_ok;
    logic [1:0]       push_n;
    logic [PC_W-1:0]  wa_pc, wb_pc;
    logic [31:0]      wa_instr, wb_instr;
    logic             wa_en, wb_en;
    logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;

    assign slot_pc[0]    = fetch_pc_reg;
    assign slot_pc[1]    = fetch_pc_reg + 1'b1;
    assign slot_instr[0] = fq.imem_data0;
    assign slot_instr[1] = fq.imem_data1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
`ifdef FQ_NOP_SQUASH_EN
            assign slot_keep[gi] = (slot_instr[gi][31:26] != 6'b111111);
`else
            assign slot_keep[gi] = 1'b1;
`endif
        end
    endgenerate

    assign wr_ptr_p1 = wr_ptr_reg + 1'b1;
    assign rd_ptr_p1 = rd_ptr_reg + 1'b1;

    always_comb begin
        pop_clip   = (fq.pop_cnt == 2'd3) ? 2'd2 : fq.pop_cnt;
        eff_pop    = (CNT_W'(pop_clip) > count_reg) ? count_reg : CNT_W'(pop_clip);
        // Space is judged after this cycle's pops, and always for a full pair even when squashing.
        free_slots = CNT_W'(DEPTH) - count_reg + eff_pop;
        push_ok    = (free_slots >= CNT_W'(2));
        push_n     = {1'b0, slot_keep[0]} + {1'b0, slot_keep[1]};

        // Compact surviving slots so entry A is always the older kept word.
        wa_pc      = slot_keep[0] ? slot_pc[0]    : slot_pc[1];
        wa_instr   = slot_keep[0] ? slot_instr[0] : slot_instr[1];
        wb_pc      = slot_pc[1];
        wb_instr   = slot_instr[1];
        wa_en      = push_ok && !fq.redirect && (push_n != 2'd0);
        wb_en      = push_ok && !fq.redirect && (push_n == 2'd2);

        fetch_pc_next = fetch_pc_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        if (fq.redirect) begin
            fetch_pc_next = fq.redirect_pc;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(eff_pop);
            count_next  = count_reg - eff_pop;
            if (push_ok) begin
                fetch_pc_next = fetch_pc_reg + PC_W'(2);
                wr_ptr_next   = wr_ptr_reg + PTR_W'(push_n);
                count_next    = count_reg - eff_pop + CNT_W'(push_n);
            end
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg <= RESET_PC_V;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
        end
    end

    always_ff @(posedge clk1) begin
        if (wa_en) begin
            pc_mem[wr_ptr_reg]    <= wa_pc;
            instr_mem[wr_ptr_reg] <= wa_instr;
        end
        if (wb_en) begin
            pc_mem[wr_ptr_p1]    <= wb_pc;
            instr_mem[wr_ptr_p1] <= wb_instr;
        end
    end

    assign fq.imem_addr0 = slot_pc[0];
    assign fq.imem_addr1 = slot_pc[1];
    assign fq.out0_valid = (count_reg >= CNT_W'(1));
    assign fq.out1_valid = (count_reg >= CNT_W'(2));
    assign fq.out0_pc    = pc_mem[rd_ptr_reg];
    assign fq.out0_instr = instr_mem[rd_ptr_reg];
    assign fq.out1_pc    = pc_mem[rd_ptr_p1];
    assign fq.out1_instr = instr_mem[rd_ptr_p1];
    assign fq.fq_count   = count_reg;
endmodule

// File: tb/tb_ssp_fetch_queue.sv
// Randomized bench for ssp_fetch_queue against a queue-based reference model, plus literal pins.
module tb_ssp_fetch_queue;
    localparam int PC_W  = 10;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    ssp_fetch_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) fq ();

    ssp_fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk1  (clk1),
        .reset (rst_n),
        .fq    (fq.master)
    );

    logic [31:0] tb_mem [1024];
    assign fq.imem_data0 = tb_mem[fq.imem_addr0];
    assign fq.imem_data1 = tb_mem[fq.imem_addr1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain list of {pc,instr} plus the next sequential fetch address.
    ent_t            m_q[$];
    logic [PC_W-1:0] m_fpc = '0;

    function automatic logic is_nop(input logic [31:0] w);
`ifdef FQ_NOP_SQUASH_EN
        return w[31:26] == 6'b111111;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_fpc = '0;
        end else begin
            int want;
            int take;
            logic [PC_W-1:0] p1;
            want = (fq.pop_cnt == 2'd3) ? 2 : int'(fq.pop_cnt);
            take = (want < m_q.size()) ? want : m_q.size();
            if (fq.redirect) begin
                m_q.delete();
                m_fpc = fq.redirect_pc;
            end else begin
                for (int i = 0; i < take; i++) void'(m_q.pop_front());
                if (DEPTH - m_q.size() >= 2) begin
                    p1 = m_fpc + 1'b1;
                    if (!is_nop(tb_mem[m_fpc])) m_q.push_back({m_fpc, tb_mem[m_fpc]});
                    if (!is_nop(tb_mem[p1]))    m_q.push_back({p1, tb_mem[p1]});
                    m_fpc = m_fpc + 10'd2;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs vs. the model.
    always @(negedge clk1) begin
        logic [PC_W-1:0] e_a1;
        e_a1 = m_fpc + 1'b1;
        chk("fq_count", 64'(fq.fq_count), 64'(m_q.size()));
        chk("out0_valid", 64'(fq.out0_valid), 64'(m_q.size() >= 1));
        chk("out1_valid", 64'(fq.out1_valid), 64'(m_q.size() >= 2));
        chk("imem_addr0", 64'(fq.imem_addr0), 64'(m_fpc));
        chk("imem_addr1", 64'(fq.imem_addr1), 64'(e_a1));
        if (m_q.size() >= 1) begin
            chk("out0_pc", 64'(fq.out0_pc), 64'(m_q[0].pc));
            chk("out0_instr", 64'(fq.out0_instr), 64'(m_q[0].instr));
        end
        if (m_q.size() >= 2) begin
            chk("out1_pc", 64'(fq.out1_pc), 64'(m_q[1].pc));
            chk("out1_instr", 64'(fq.out1_instr), 64'(m_q[1].instr));
        end
    end

    // Drive inputs, let one rising edge apply them, then sit just after the falling edge.
    task automatic step(input logic [1:0] pop, input logic redir, input logic [PC_W-1:0] rpc);
        fq.pop_cnt     = pop;
        fq.redirect    = redir;
        fq.redirect_pc = rpc;
        @(negedge clk1);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (i >= 32 && $urandom_range(7) == 0) w[31:26] = 6'b111111;
            else if (w[31:26] == 6'b111111)        w[31:26] = 6'b000000;
            tb_mem[i] = w;
        end
        fq.pop_cnt     = 2'd0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        repeat (3) @(negedge clk1);
        #1;
        rst_n = 1'b1;

        // Edge 1 after reset release.
        @(negedge clk1); #1;
        chk("pin_reset_out0_pc", 64'(fq.out0_pc), 64'd0);
        chk("pin_reset_out1_pc", 64'(fq.out1_pc), 64'd1);
        chk("pin_reset_count", 64'(fq.fq_count), 64'd2);
        chk("pin_reset_addr0", 64'(fq.imem_addr0), 64'd2);

        // Fill and stall.
        repeat (3) step(2'd0, 1'b0, '0);
        chk("pin_fill_count", 64'(fq.fq_count), 64'd8);
        chk("pin_fill_addr0", 64'(fq.imem_addr0), 64'd8);
        step(2'd0, 1'b0, '0);
        chk("pin_stall_addr0", 64'(fq.imem_addr0), 64'd8);
        step(2'd2, 1'b0, '0);
        chk("pin_resume_count", 64'(fq.fq_count), 64'd8);
        chk("pin_resume_addr0", 64'(fq.imem_addr0), 64'd10);
        chk("pin_resume_out0_pc", 64'(fq.out0_pc), 64'd2);

        // Streaming from an empty queue.
        step(2'd0, 1'b1, 10'd0);
        for (int k = 0; k < 4; k++) begin
            step(2'd2, 1'b0, '0);
            chk("pin_stream_count", 64'(fq.fq_count), 64'd2);
            chk("pin_stream_out0_pc", 64'(fq.out0_pc), 64'(2 * k));
        end

        // Redirect with four entries queued.
        step(2'd0, 1'b1, 10'd0);
        step(2'd0, 1'b0, '0);
        step(2'd0, 1'b0, '0);
        chk("pin_redir_pre_count", 64'(fq.fq_count), 64'd4);
        step(2'd1, 1'b1, 10'd18);
        chk("pin_redir_count", 64'(fq.fq_count), 64'd0);
        chk("pin_redir_addr0", 64'(fq.imem_addr0), 64'd18);
        step(2'd0, 1'b0, '0);
        chk("pin_redir_out0_pc", 64'(fq.out0_pc), 64'd18);
        chk("pin_redir_out1_pc", 64'(fq.out1_pc), 64'd19);

        // Back-to-back redirects; the second (odd) target wins.
        step(2'd0, 1'b1, 10'd18);
        chk("pin_b2b_count1", 64'(fq.fq_count), 64'd0);
        step(2'd0, 1'b1, 10'd9);
        chk("pin_b2b_count2", 64'(fq.fq_count), 64'd0);
        chk("pin_b2b_addr0", 64'(fq.imem_addr0), 64'd9);
        step(2'd0, 1'b0, '0);
        chk("pin_b2b_out0_pc", 64'(fq.out0_pc), 64'd9);
        chk("pin_b2b_out1_pc", 64'(fq.out1_pc), 64'd10);

        // pop_cnt=3 behaves as 2.
        step(2'd3, 1'b0, '0);
        chk("pin_overpop_count", 64'(fq.fq_count), 64'd2);
        chk("pin_overpop_out0_pc", 64'(fq.out0_pc), 64'd11);

        // Randomized traffic, including targets near the address wrap.
        for (int n = 0; n < 3000; n++) begin
            logic [PC_W-1:0] tgt;
            logic            rd;
            rd  = ($urandom_range(15) == 0);
            tgt = ($urandom_range(3) == 0) ? PC_W'(1022 + $urandom_range(1)) : PC_W'($urandom_range(1023));
            step(2'($urandom_range(3)), rd, tgt);
        end

        // Mid-run reset: outputs must go invalid immediately.
        rst_n = 1'b0;
        #1;
        chk("pin_async_reset_count", 64'(fq.fq_count), 64'd0);
        chk("pin_async_reset_valid", 64'(fq.out0_valid), 64'd0);
        step(2'd0, 1'b0, '0);
        rst_n = 1'b1;
        step(2'd0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
